// File: rtl/koopa_sprite_sequencer.sv
// koopa_sprite_sequencer: per-player animation FSMs and mirrored ROM address generation for the koopa sprite ROM.
// Optional KOOPA_HIT_BLINK_EN: sprite blinks on alternate frame_ticks while a player is in HIT.
module koopa_sprite_sequencer #(
   parameter int SPR_W           = 23,
   parameter int SPR_H           = 30,
   parameter int TICKS_PER_FRAME = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic [9:0]  draw_x,
   input  logic [9:0]  draw_y,
   input  logic [9:0]  p1_x,
   input  logic [9:0]  p2_x,
   input  logic [9:0]  p1_y,
   input  logic [9:0]  p2_y,
   input  logic        p1_face_left,
   input  logic        p2_face_left,
   input  logic [2:0]  p1_anim_req,
   input  logic [2:0]  p2_anim_req,
   output logic [13:0] addr1,
   output logic [13:0] addr2,
   output logic        p1_on,
   output logic        p2_on,
   output logic [2:0]  p1_anim,
   output logic [2:0]  p2_anim,
   output logic        p1_busy,
   output logic        p2_busy
);
   typedef enum logic [2:0] {IDLE, WALK, JUMP, ATTACK, HIT} state_t;

   function automatic logic [3:0] first_frame(state_t s);
      return (s == WALK) ? 4'd2 : (s == JUMP) ? 4'd6 : (s == ATTACK) ? 4'd8 : (s == HIT) ? 4'd11 : 4'd0;
   endfunction

   function automatic logic [3:0] last_frame(state_t s);
      return (s == WALK) ? 4'd5 : (s == JUMP) ? 4'd7 : (s == ATTACK) ? 4'd10 : (s == HIT) ? 4'd13 : 4'd1;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : pl
      logic [9:0]  px, py, dx, dy, col;
      logic        face, in_box, sw, adv, last, on_d, on_q, busy;
      logic [2:0]  req;
      state_t      req_s, state_d, state_q;
      logic [3:0]  frame_d, frame_q, tick_d, tick_q;
      logic [13:0] addr_d, addr_q;
      assign px   = (g == 0) ? p1_x : p2_x;
      assign py   = (g == 0) ? p1_y : p2_y;
      assign face = (g == 0) ? p1_face_left : p2_face_left;
      assign req  = (g == 0) ? p1_anim_req : p2_anim_req;
      assign busy = (state_q == ATTACK) || (state_q == HIT);
      always_comb begin
         req_s   = (req > 3'd4) ? IDLE : state_t'(req);
         // ATTACK yields only to HIT; HIT yields to nothing until it finishes
         sw      = (state_q == ATTACK) ? (req_s == HIT) : (state_q != HIT) && (req_s != state_q);
         adv     = frame_tick && (tick_q == 4'(TICKS_PER_FRAME - 1));
         last    = frame_q == last_frame(state_q);
         state_d = state_q;
         frame_d = frame_q;
         tick_d  = tick_q;
         if (sw) begin
            state_d = req_s;
            frame_d = first_frame(req_s);
            tick_d  = '0;
         end else if (adv) begin
            tick_d = '0;
            if (!last)
               frame_d = frame_q + 4'd1;
            else if (busy) begin
               state_d = req_s;
               frame_d = first_frame(req_s);
            end else
               frame_d = (state_q == JUMP) ? frame_q : first_frame(state_q);
         end else if (frame_tick)
            tick_d = tick_q + 4'd1;
      end
      // unsigned wrap makes left/above offsets huge, so one compare per axis suffices
      always_comb begin
         dx     = draw_x - px;
         dy     = draw_y - py;
         in_box = (dx < 10'(SPR_W)) && (dy < 10'(SPR_H));
         col    = face ? 10'(SPR_W - 1) - dx : dx;
         addr_d = in_box ? 14'(frame_q) * 14'(SPR_W * SPR_H) + 14'(dy) * 14'(SPR_W) + 14'(col) : '0;
      end
`ifdef KOOPA_HIT_BLINK_EN
      logic blink_d, blink_q;
      assign blink_d = (state_q == HIT && state_d == HIT) ? blink_q ^ frame_tick : 1'b0;
      assign on_d    = in_box && !blink_q;
      always_ff @(posedge clk or posedge reset) begin
         if (reset)
            blink_q <= 1'b0;
         else
            blink_q <= blink_d;
      end
`else
      assign on_d = in_box;
`endif
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q <= IDLE;
            frame_q <= '0;
            tick_q  <= '0;
            addr_q  <= '0;
            on_q    <= 1'b0;
         end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            tick_q  <= tick_d;
            addr_q  <= addr_d;
            on_q    <= on_d;
         end
      end
   end

   assign addr1   = pl[0].addr_q;
   assign addr2   = pl[1].addr_q;
   assign p1_on   = pl[0].on_q;
   assign p2_on   = pl[1].on_q;
   assign p1_anim = pl[0].state_q;
   assign p2_anim = pl[1].state_q;
   assign p1_busy = pl[0].busy;
   assign p2_busy = pl[1].busy;
endmodule
